// File: rtl/serial_crc8.sv
// Bit-serial CRC-8 generator/checker: folds MSB-first bits into an 8-bit LFSR and hands off CRC + length.
// Optional zero-residue flag out_ok is compiled in with `define SERIAL_CRC8_CHECK_EN.
module serial_crc8 #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_crc,
  output logic [15:0] out_len
`ifdef SERIAL_CRC8_CHECK_EN
  ,
  output logic        out_ok
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state;
  logic [7:0]  crc;
  logic [15:0] len;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  function automatic logic [15:0] len_sat_inc(input logic [15:0] l);
    return (l == 16'hFFFF) ? l : l + 16'd1;
  endfunction

  assign in_ready = !out_valid;
  assign out_crc  = crc;
  assign out_len  = len;

`ifdef SERIAL_CRC8_CHECK_EN
  assign out_ok = out_valid && (crc == 8'h00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= INIT;
      len       <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            crc <= crc_step(crc, in_bit);
            len <= len_sat_inc(len);
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until taken; the handoff edge also rearms the frame registers.
          if (out_ready) begin
            state     <= IDLE;
            crc       <= INIT;
            len       <= 16'd0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          crc       <= INIT;
          len       <= 16'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_crc8.md
# serial_crc8

Bit-serial CRC-8 generator/checker built around a chain of XOR stages. It is the upstream consumer of single-bit XOR logic in the combinational-logic exercises. Frames arrive MSB-first, one bit per accepted beat, with valid/ready handshaking. The block folds each bit into an 8-bit LFSR, then presents the final CRC and frame length on an output handshake. It sits between a serial bit source and any byte-level consumer or checker.

## Interface
- POLY, 8'h07, generator polynomial without the implicit x^8 term
- INIT, 8'h00, CRC register value at reset and at the start of every frame
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_bit and in_last are valid this cycle
- in_ready  output  1  block can accept a bit this cycle
- in_bit  input  1  serial data bit, MSB-first
- in_last  input  1  marks the final bit of the frame
- out_valid  output  1  out_crc and out_len hold a completed frame result
- out_ready  input  1  downstream accepts the result
- out_crc  output  8  final CRC register value
- out_len  output  16  number of bits in the frame, saturating

## Operation
- States:
  - IDLE: no frame in progress; crc = INIT, len = 0.
  - ACCUM: at least one bit of the frame has been accepted.
  - HOLD: result is presented.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD. in_ready = !out_valid.
- Accept: when in_valid && in_ready:
  - fb = crc[7] ^ in_bit
  - crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00)
  - len <= len + 1, saturating at 16'hFFFF
- Transitions:
  - IDLE to ACCUM on an accepted bit with in_last = 0.
  - IDLE or ACCUM to HOLD on an accepted bit with in_last = 1. A single-bit frame is legal.
  - HOLD to IDLE on out_ready. That edge reloads crc to INIT and len to 0.
- in_valid while in_ready = 0: bit and last are ignored and are not stored.
- in_last without in_valid: ignored.
- out_crc and out_len are stable for the whole time out_valid is high.
- Outside HOLD, out_crc and out_len show the live register values. Consumers must qualify them with out_valid.
- All arithmetic is unsigned. The CRC is purely shift/XOR with no carries.

## Timing
- Reset values: state IDLE, crc = INIT, len = 0, out_valid = 0, in_ready = 1, out_crc = INIT, out_len = 0. With the check feature compiled in, out_ok = 0 (see Configuration).
- Throughput: one bit per cycle while in_valid is held high.
- Latency: out_valid rises on the clock edge that accepts the in_last bit. It is visible the cycle after that bit was presented.
- out_valid && out_ready completes the output handshake in that cycle. in_ready returns to 1 the following cycle, so the minimum gap between frames is 1 cycle.
- out_ready while out_valid = 0: no effect.
- Reset asserted mid-frame or during HOLD: everything returns immediately to the reset values. The partial frame is discarded.

## Configuration
- SERIAL_CRC8_CHECK_EN defined:
  - Adds output port out_ok (1 bit).
  - out_ok = out_valid && (out_crc == 8'h00), i.e. the frame, with its CRC byte appended, has a zero residue.
  - Reset value of out_ok is 0.
- SERIAL_CRC8_CHECK_EN undefined: port out_ok and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-frame after 5 bits → next cycle in_ready = 1, out_valid = 0, out_crc = 8'h00, out_len = 0. A following frame 8'h01 gives out_crc = 8'h07.
- Byte frame: send 8'h01 MSB-first with in_last on bit 8, in_valid held high → out_valid = 1 the next cycle, out_crc = 8'h07, out_len = 8.
- Residue check: send 16 bits 8'h01 then 8'h07 → out_crc = 8'h00, out_len = 16; out_ok = 1 when SERIAL_CRC8_CHECK_EN is defined.
- Single bit: one bit 1 with in_last → out_crc = 8'h07, out_len = 1.
- Backpressure: hold out_ready = 0 for 10 cycles while in_valid stays high:
  - out_crc and out_len stay stable, and in_ready = 0.
  - Offered bits are not absorbed.
  - Raising out_ready gives in_ready = 1 the next cycle, with crc = INIT and len = 0.
- Gapped input: 8'h01 sent with in_valid toggling every other cycle → same result as back-to-back, out_crc = 8'h07.
